// File: rtl/usb_tx_arbiter.sv
// rtl/usb_tx_arbiter.sv - two-requester SIE transmit arbiter with alternating grant and watchdog
module usb_tx_arbiter #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 11
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       arbEn,
    input  logic       hcTxWEn,
    input  logic [3:0] hcTxPID,
    output logic       hcTxRdy,
    input  logic       scTxWEn,
    input  logic [3:0] scTxPID,
    output logic       scTxRdy,
    output logic       sieTxWEn,
    output logic [3:0] sieTxPID,
    input  logic       sieTxRdy,
    output logic [1:0] grant,
    output logic       timeoutErr,
    output logic [1:0] reqOverrun
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       pend_q, pend_d;
    logic [3:0]       hc_pid_q, hc_pid_d;
    logic [3:0]       sc_pid_q, sc_pid_d;
    logic             last_q, last_d;     // 1 = SC owned the previous grant
    logic             owner_q, owner_d;   // 0 = HC, 1 = SC
    logic             hc_rdy_q, hc_rdy_d;
    logic             sc_rdy_q, sc_rdy_d;
    logic             wen_q, wen_d;
    logic [3:0]       pid_out_q, pid_out_d;
    logic [1:0]       grant_q, grant_d;
    logic             tmo_q, tmo_d;
    logic [1:0]       ovr_q, ovr_d;

    logic             release_c;
    logic             sel_c;
    logic [1:0]       pend_rel_c;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        owner_d   = owner_q;
        pid_out_d = pid_out_q;
        grant_d   = grant_q;
        wen_d     = 1'b0;
        tmo_d     = 1'b0;
        release_c = 1'b0;
        sel_c     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (arbEn && sieTxRdy && (pend_q != 2'b00)) begin
                    // On contention the requester that did not own the last grant wins.
                    sel_c     = (pend_q == 2'b11) ? ~last_q : pend_q[1];
                    owner_d   = sel_c;
                    last_d    = sel_c;
                    state_d   = S_ISSUE;
                    wen_d     = 1'b1;
                    pid_out_d = sel_c ? sc_pid_q : hc_pid_q;
                    grant_d   = sel_c ? 2'b10 : 2'b01;
                    cnt_d     = '0;
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (sieTxRdy) begin
                    release_c = 1'b1;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    release_c = 1'b1;
                    tmo_d     = 1'b1;
                end
                if (release_c) begin
                    state_d = S_IDLE;
                    grant_d = 2'b00;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A release frees the owner's slot in time for a WEn arriving in the same cycle.
        pend_rel_c = pend_q & ~(release_c ? (owner_q ? 2'b10 : 2'b01) : 2'b00);
        pend_d     = pend_rel_c;
        hc_pid_d   = hc_pid_q;
        sc_pid_d   = sc_pid_q;
        ovr_d      = 2'b00;

        if (hcTxWEn) begin
            if (pend_rel_c[0]) begin
                ovr_d[0] = 1'b1;
            end else begin
                pend_d[0] = 1'b1;
                hc_pid_d  = hcTxPID;
            end
        end
        if (scTxWEn) begin
            if (pend_rel_c[1]) begin
                ovr_d[1] = 1'b1;
            end else begin
                pend_d[1] = 1'b1;
                sc_pid_d  = scTxPID;
            end
        end

        hc_rdy_d = ~pend_d[0];
        sc_rdy_d = ~pend_d[1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            pend_q    <= 2'b00;
            hc_pid_q  <= 4'h0;
            sc_pid_q  <= 4'h0;
            last_q    <= 1'b1;
            owner_q   <= 1'b0;
            hc_rdy_q  <= 1'b1;
            sc_rdy_q  <= 1'b1;
            wen_q     <= 1'b0;
            pid_out_q <= 4'h0;
            grant_q   <= 2'b00;
            tmo_q     <= 1'b0;
            ovr_q     <= 2'b00;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            hc_pid_q  <= hc_pid_d;
            sc_pid_q  <= sc_pid_d;
            last_q    <= last_d;
            owner_q   <= owner_d;
            hc_rdy_q  <= hc_rdy_d;
            sc_rdy_q  <= sc_rdy_d;
            wen_q     <= wen_d;
            pid_out_q <= pid_out_d;
            grant_q   <= grant_d;
            tmo_q     <= tmo_d;
            ovr_q     <= ovr_d;
        end
    end

    assign hcTxRdy    = hc_rdy_q;
    assign scTxRdy    = sc_rdy_q;
    assign sieTxWEn   = wen_q;
    assign sieTxPID   = pid_out_q;
    assign grant      = grant_q;
    assign timeoutErr = tmo_q;
    assign reqOverrun = ovr_q;
endmodule

// File: tb/tb_usb_tx_arbiter.sv
// tb/tb_usb_tx_arbiter.sv - scoreboard bench for usb_tx_arbiter
module tb_usb_tx_arbiter;
    localparam int TMO = 8;

    logic       clk = 1'b0;
    logic       rst_n, arbEn, hcTxWEn, scTxWEn, sieTxRdy;
    logic [3:0] hcTxPID, scTxPID;
    logic       hcTxRdy, scTxRdy, sieTxWEn, timeoutErr;
    logic [3:0] sieTxPID;
    logic [1:0] grant, reqOverrun;

    usb_tx_arbiter #(.TIMEOUT_CYCLES(TMO), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .arbEn(arbEn),
        .hcTxWEn(hcTxWEn), .hcTxPID(hcTxPID), .hcTxRdy(hcTxRdy),
        .scTxWEn(scTxWEn), .scTxPID(scTxPID), .scTxRdy(scTxRdy),
        .sieTxWEn(sieTxWEn), .sieTxPID(sieTxPID), .sieTxRdy(sieTxRdy),
        .grant(grant), .timeoutErr(timeoutErr), .reqOverrun(reqOverrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] grant;
        logic [3:0] pid;
        bit         tmo;
    } exp_t;

    exp_t exp_q[$];
    int   dly_q[$];
    int   n_cmp = 0, n_err = 0;
    int   edge_cnt = 0;
    int   last_issue_edge = -1, prev_issue_edge = -1, n_issue = 0;
    int   tmo_seen = 0, tmo_exp = 0, ovr_seen = 0;
    int   drive_edge = 0;
    bit   cur_tmo = 1'b0;
    bit   model_last_sc = 1'b1;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every issue and audits watchdog pulses.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                cur_tmo = 1'b0;
                continue;
            end
            if (sieTxWEn) begin
                prev_issue_edge = last_issue_edge;
                last_issue_edge = edge_cnt;
                n_issue++;
                if (exp_q.size() == 0) begin
                    check("unexpected_issue", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("issue_grant", grant, e.grant);
                    check("issue_pid", sieTxPID, e.pid);
                    cur_tmo = e.tmo;
                end
            end
            if (timeoutErr) begin
                tmo_seen++;
                check("timeout_expected", cur_tmo, 1);
                check("timeout_latency", edge_cnt - last_issue_edge, TMO + 1);
                cur_tmo = 1'b0;
            end
            if (reqOverrun != 2'b00) ovr_seen++;
        end
    end

    // SIE model: drops ready on each strobe, raises it again after the queued delay.
    initial begin
        int d;
        sieTxRdy = 1'b1;
        forever begin
            @(negedge clk);
            if (rst_n && sieTxWEn) begin
                d = (dly_q.size() != 0) ? dly_q.pop_front() : 1;
                sieTxRdy = 1'b0;
                repeat (d) @(negedge clk);
                sieTxRdy = 1'b1;
            end
        end
    end

    function automatic void expect_txn(input bit sc, input logic [3:0] pid, input int d);
        exp_t e;
        e.grant = sc ? 2'b10 : 2'b01;
        e.pid   = pid;
        e.tmo   = (d > TMO);
        exp_q.push_back(e);
        dly_q.push_back(d);
        if (e.tmo) tmo_exp++;
        model_last_sc = sc;
    endfunction

    task automatic req(input bit h, input bit s, input logic [3:0] hp, input logic [3:0] sp, input int d);
        if (h && s) begin
            if (model_last_sc) begin
                expect_txn(1'b0, hp, d);
                expect_txn(1'b1, sp, d);
            end else begin
                expect_txn(1'b1, sp, d);
                expect_txn(1'b0, hp, d);
            end
        end else if (h) begin
            expect_txn(1'b0, hp, d);
        end else if (s) begin
            expect_txn(1'b1, sp, d);
        end
        @(negedge clk);
        drive_edge = edge_cnt;
        hcTxWEn = h; hcTxPID = hp;
        scTxWEn = s; scTxPID = sp;
        @(negedge clk);
        hcTxWEn = 1'b0;
        scTxWEn = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while (!(hcTxRdy && scTxRdy && sieTxRdy && grant == 2'b00 && exp_q.size() == 0) && k < 400) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (k >= 400) check(name, 0, 1);
    endtask

    task automatic wait_issue(input string name);
        int n0 = n_issue;
        int k  = 0;
        while (n_issue == n0 && k < 100) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (k >= 100) check(name, 0, 1);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        model_last_sc = 1'b1;
        rst_n = 1'b1;
    endtask

    initial begin
        int n0, ov0, t0, kind, d;
        logic [3:0] p1, p2;
        rst_n = 1'b0; arbEn = 1'b1;
        hcTxWEn = 1'b0; scTxWEn = 1'b0; hcTxPID = 4'h0; scTxPID = 4'h0;
        repeat (3) @(negedge clk);
        check("rst_hcTxRdy", hcTxRdy, 1);
        check("rst_scTxRdy", scTxRdy, 1);
        check("rst_sieTxWEn", sieTxWEn, 0);
        check("rst_sieTxPID", sieTxPID, 0);
        check("rst_grant", grant, 0);
        check("rst_timeoutErr", timeoutErr, 0);
        check("rst_reqOverrun", reqOverrun, 0);
        rst_n = 1'b1;

        // Single HC request: issue two edges after the strobe.
        req(1'b1, 1'b0, 4'h1, 4'h0, 5);
        wait_issue("t1_issue_timeout");
        check("t1_latency", last_issue_edge - drive_edge, 2);
        check("t1_hcTxRdy_busy", hcTxRdy, 0);
        check("t1_scTxRdy_idle", scTxRdy, 1);
        wait_idle("t1_idle_timeout");

        // Simultaneous requests after reset: HC first, SC back-to-back.
        pulse_reset();
        req(1'b1, 1'b1, 4'h9, 4'ha, 3);
        wait_idle("t2_idle_timeout");
        check("t2_back_to_back_gap", last_issue_edge - prev_issue_edge, 3 + 2);

        // Alternation over four transactions.
        req(1'b1, 1'b1, 4'h2, 4'h3, 2);
        wait_idle("t3a_idle_timeout");
        req(1'b1, 1'b1, 4'h4, 4'h5, 1);
        wait_idle("t3b_idle_timeout");

        // Watchdog, then a normal request.
        req(1'b0, 1'b1, 4'hb, 4'hd, 20);
        wait_idle("t4_idle_timeout");
        check("t4_timeouts", tmo_seen, tmo_exp);
        req(1'b0, 1'b1, 4'h0, 4'he, 2);
        wait_idle("t4b_idle_timeout");

        // Overrun while held off by arbEn, then enable.
        arbEn = 1'b0;
        req(1'b0, 1'b1, 4'h0, 4'h5, 2);
        n0 = n_issue;
        scTxWEn = 1'b1; scTxPID = 4'h6;
        @(negedge clk);
        scTxWEn = 1'b0;
        check("t5_reqOverrun", reqOverrun, 2'b10);
        repeat (4) @(negedge clk);
        check("t5_no_issue_when_disabled", n_issue, n0);
        arbEn = 1'b1;
        t0 = edge_cnt;
        wait_issue("t5_issue_timeout");
        check("t5_enable_latency", last_issue_edge - t0, 1);
        wait_idle("t5_idle_timeout");

        // WEn in the release cycle is accepted without overrun.
        req(1'b1, 1'b0, 4'h3, 4'h0, 3);
        wait_issue("t6_issue_timeout");
        n0 = 0;
        while (!sieTxRdy && n0 < 50) begin
            @(negedge clk);
            #1;
            n0++;
        end
        ov0 = ovr_seen;
        expect_txn(1'b0, 4'hc, 2);
        hcTxWEn = 1'b1; hcTxPID = 4'hc;
        @(negedge clk);
        hcTxWEn = 1'b0;
        check("t6_rdy_stays_low", hcTxRdy, 0);
        wait_idle("t6_idle_timeout");
        check("t6_no_overrun", ovr_seen, ov0);

        // Asynchronous reset during WAIT.
        req(1'b1, 1'b0, 4'h7, 4'h0, 6);
        wait_issue("t7_issue_timeout");
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t7_hcTxRdy", hcTxRdy, 1);
        check("t7_sieTxWEn", sieTxWEn, 0);
        check("t7_sieTxPID", sieTxPID, 0);
        check("t7_grant", grant, 0);
        check("t7_timeoutErr", timeoutErr, 0);
        model_last_sc = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        wait_idle("t7_idle_timeout");

        // Randomized traffic against the transaction-level model.
        for (int i = 0; i < 24; i++) begin
            kind = $urandom_range(0, 2);
            d    = ($urandom_range(0, 4) == 0) ? 20 : $urandom_range(1, 6);
            p1   = 4'($urandom);
            p2   = 4'($urandom);
            req(kind != 1, kind != 0, p1, p2, d);
            wait_idle("rand_idle_timeout");
        end

        check("total_timeouts", tmo_seen, tmo_exp);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/usb_tx_arbiter.md
# usb_tx_arbiter

Arbitrates the single SIE transmit path (packet PID send) between two requesters: the host controller (HC) and the slave controller (SC). Each requester keeps its level-style WEn/PID/Rdy handshake unchanged. The block latches requests and grants the SIE alternately when both are pending. It also watchdogs each SIE transaction so that a stuck transmitter cannot hang either controller. It sits between the two controllers and the SIE transmit front end.

## Interface
Parameters:
- TIMEOUT_CYCLES, 1024: WAIT cycles without sieTxRdy before abort.
- CNT_W, 11: timeout counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- arbEn  in  1  1 = new grants allowed; 0 = in-flight grant completes, no new grant.
- hcTxWEn  in  1  HC send request strobe (1 cycle).
- hcTxPID  in  4  HC PID, valid with hcTxWEn.
- hcTxRdy  out  1  level; 1 = HC has nothing pending or in flight.
- scTxWEn  in  1  SC send request strobe.
- scTxPID  in  4  SC PID, valid with scTxWEn.
- scTxRdy  out  1  level; 1 = SC has nothing pending or in flight.
- sieTxWEn  out  1  one-cycle strobe to SIE.
- sieTxPID  out  4  PID to SIE; held from issue until release.
- sieTxRdy  in  1  SIE level ready, 1 = idle.
- grant  out  2  one-hot owner: [0] = HC, [1] = SC; 00 = none.
- timeoutErr  out  1  one-cycle pulse on watchdog abort.
- reqOverrun  out  2  one-cycle pulse per requester: WEn received while already pending. [0] = HC, [1] = SC.

## Operation
- All outputs are registered. Reset values: hcTxRdy = scTxRdy = 1, sieTxWEn = 0, sieTxPID = 0, grant = 00, timeoutErr = 0, reqOverrun = 00. Internal state at reset: pending bits = 0, lastOwner = SC, state = IDLE.
- Request capture:
  - xxTxWEn with pending = 0 sets pending, latches the PID, and drives xxTxRdy to 0 on the next edge.
  - xxTxWEn with pending = 1 is dropped; the latched PID is kept and reqOverrun[x] pulses.
- Arbitration, evaluated in IDLE only when arbEn = 1 and sieTxRdy = 1:
  - Exactly one pending: grant it.
  - Both pending: grant the one that is not lastOwner.
  - lastOwner updates on every grant.
- State machine:
  - IDLE: on grant, go to ISSUE. Registered outputs: sieTxWEn = 1, sieTxPID = owner PID, grant = owner one-hot, counter cleared.
  - ISSUE: one cycle. sieTxWEn returns to 0. sieTxRdy is ignored here because the SIE is still dropping ready. Go to WAIT.
  - WAIT: counter increments each cycle.
    - sieTxRdy = 1: go to IDLE, clear owner pending, set owner xxTxRdy = 1, grant = 00.
    - Otherwise, counter == TIMEOUT_CYCLES-1: same release, plus timeoutErr = 1 for one cycle.
- arbEn deassert mid-transaction has no effect on the current grant.
- Same-cycle events:
  - WEn in the same cycle as that requester's release: the WEn is a new request and is accepted (pending set, Rdy stays 0). No overrun.
  - Both WEn in the same cycle while idle: both are captured. The tie is resolved by lastOwner, so HC wins first after reset.
- rst_n assertion at any time asynchronously forces the reset values and abandons any in-flight transaction. No Rdy or timeout pulse is generated.

## Timing
- Request-to-issue latency: WEn at edge n → pending at n+1 → sieTxWEn high during cycle n+2, when the SIE is ready and there is no contention.
- Release: sieTxRdy sampled high in WAIT at edge m → xxTxRdy = 1 and grant = 00 from m+1.
- Back-to-back: the earliest next sieTxWEn is cycle m+2 (IDLE re-arbitrates at m+1).
- Timeout: release occurs TIMEOUT_CYCLES cycles after entering WAIT.
- Counter width: CNT_W bits, saturating not required (cleared on each issue).

## Test plan
- Single HC request, PID 4'h1; SIE returns ready 5 cycles after issue → sieTxWEn pulse in cycle n+2 with sieTxPID = 1, grant = 01, hcTxRdy low until 1 cycle after sieTxRdy, scTxRdy stays 1.
- Both WEn in the same cycle (HC PID 4'h9, SC PID 4'ha) after reset → HC issued first, SC issued second, with back-to-back sieTxWEn exactly 2 cycles after HC release.
- Alternation: HC and SC both re-request continuously for 4 transactions → grant sequence HC, SC, HC, SC.
- Watchdog with TIMEOUT_CYCLES = 8 and sieTxRdy held 0 → timeoutErr pulses once, 8 cycles after entering WAIT; scTxRdy returns to 1; the next request is served normally.
- Overrun and edge cases:
  - Second scTxWEn while pending → reqOverrun = 10, original PID transmitted.
  - WEn on the release cycle → accepted with no overrun.
- Control and reset:
  - arbEn = 0 with a pending request → no sieTxWEn; arbEn set to 1 → issue 1 cycle later.
  - rst_n pulsed low in WAIT → all outputs at reset values asynchronously.
